sar_search: RTL and testbench

//   Successive-approximation search controller that drives the comparator from the other side.
//   It generates probe operands and consumes the eq/gte flags that come back, then converges
//   on an unknown target value held on the comparator's other input.
//   It serves binary-search uses: threshold find, SAR-ADC style conversion, and value recovery.
//   It supports unsigned and two's-complement search domains, matching the comparator's signed_cmp mode.

---
 rtl/sar_search.sv | 125 ++++++++++++
 tb/tb_sar_search.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search controller.
// Presents probe operands to an external comparator, consumes the eq/gte flags
// that come back and converges on the comparator's unknown target value.
// Signed searches run in offset-binary: the search itself is unsigned and the
// MSB of every probe and of the final result is flipped on the way out.
module sar_search #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_cmp,
    output logic [WIDTH-1:0] probe,
    output logic             probe_valid,
    input  logic             cmp_valid,
    input  logic             cmp_eq,
    input  logic             cmp_gte,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hit_eq
);

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mask_reg;
    logic             mode_reg;
    logic [WIDTH-1:0] probe_reg;
    logic             probe_valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;
    logic             hit_eq_reg;

    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] probe_next;

    // Outcome of the current compare: keep or drop the trial bit, then form the next probe.
    always_comb begin
        flip       = mode_reg ? MSB : '0;
        acc_next   = cmp_gte ? (acc_reg | mask_reg) : acc_reg;
        mask_next  = mask_reg >> 1;
        probe_next = (acc_next | mask_next) ^ flip;
    end

    // Search FSM; every output is registered so the probe only moves on a compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            acc_reg         <= '0;
            mask_reg        <= '0;
            mode_reg        <= 1'b0;
            probe_reg       <= '0;
            probe_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            result_reg      <= '0;
            hit_eq_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg        <= signed_cmp;
                        acc_reg         <= '0;
                        mask_reg        <= MSB;
                        result_reg      <= '0;
                        hit_eq_reg      <= 1'b0;
                        // First trial is the MSB alone; in signed mode that is zero.
                        probe_reg       <= signed_cmp ? '0 : MSB;
                        probe_valid_reg <= 1'b1;
                        busy_reg        <= 1'b1;
                        state_reg       <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (cmp_valid) begin
                        if (cmp_eq) begin
                            // Exact hit: stop early with the probe itself as the answer.
                            result_reg      <= probe_reg;
                            hit_eq_reg      <= 1'b1;
                            done_reg        <= 1'b1;
                            probe_reg       <= '0;
                            probe_valid_reg <= 1'b0;
                            busy_reg        <= 1'b0;
                            state_reg       <= IDLE;
                        end else if (mask_reg[0]) begin
                            // Last bit resolved: the accumulator is the target in offset form.
                            acc_reg         <= acc_next;
                            result_reg      <= acc_next ^ flip;
                            hit_eq_reg      <= 1'b0;
                            done_reg        <= 1'b1;
                            probe_reg       <= '0;
                            probe_valid_reg <= 1'b0;
                            busy_reg        <= 1'b0;
                            state_reg       <= IDLE;
                        end else begin
                            acc_reg   <= acc_next;
                            mask_reg  <= mask_next;
                            probe_reg <= probe_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign probe       = probe_reg;
    assign probe_valid = probe_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign result      = result_reg;
    assign hit_eq      = hit_eq_reg;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: a behavioural comparator answers the probes,
// a reference model predicts the probe sequence and the result of each search.
module tb_sar_search;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_cmp = 1'b0;
    logic [W-1:0] probe;
    logic         probe_valid;
    logic         cmp_valid = 1'b0;
    logic         cmp_eq;
    logic         cmp_gte;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         hit_eq;

    logic [W-1:0] target = '0;
    logic         cur_mode = 1'b0;

    typedef struct {
        logic [W-1:0] res;
        logic         hit;
    } exp_t;

    exp_t         exp_res[$];
    logic [W-1:0] exp_probe[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    sar_search #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_cmp(signed_cmp),
        .probe(probe), .probe_valid(probe_valid), .cmp_valid(cmp_valid),
        .cmp_eq(cmp_eq), .cmp_gte(cmp_gte), .busy(busy), .done(done),
        .result(result), .hit_eq(hit_eq)
    );

    always #5 clk = ~clk;

    // Behavioural comparator holding the unknown target.
    assign cmp_eq  = (target == probe);
    assign cmp_gte = cur_mode ? ($signed(target) >= $signed(probe)) : (target >= probe);

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: binary search over the offset-binary target. The trial at bit k
    // is the target's bits above k with bit k set; it stops when a trial equals the target.
    // Returns the number of compares and pushes the expected probes and result.
    function automatic int model_push(input logic [W-1:0] t, input logic m);
        int tp, trial, n;
        exp_t e;
        tp = int'(t) ^ (m ? (1 << (W-1)) : 0);
        n = 0;
        for (int k = W-1; k >= 0; k--) begin
            trial = (tp & ~((1 << (k+1)) - 1)) | (1 << k);
            exp_probe.push_back(W'(trial ^ (m ? (1 << (W-1)) : 0)));
            n++;
            if (trial == tp) break;
        end
        e.res = t;
        e.hit = (tp != 0);
        exp_res.push_back(e);
        return n;
    endfunction

    // Monitor: compares each accepted probe, each done, and probe stability across stalls.
    logic [W-1:0] prev_probe = '0;
    logic         prev_stall = 1'b0;
    always @(negedge clk) begin
        if (probe_valid && prev_stall) begin
            check("stall_probe_stable", probe, prev_probe);
            check("stall_busy", busy, 1);
        end
        if (probe_valid && cmp_valid) begin
            if (exp_probe.size() == 0) check("unexpected_probe", probe, 0);
            else check("probe", probe, exp_probe.pop_front());
        end
        if (done) begin
            if (exp_res.size() == 0) begin
                total_cnt++;
                $display("FAIL done_unexpected: got done=1 result %0h expected no done", result);
            end else begin
                exp_t e;
                e = exp_res.pop_front();
                check("result", result, e.res);
                check("hit_eq", hit_eq, e.hit);
                check("busy_at_done", busy, 0);
            end
        end
        prev_stall = probe_valid && !cmp_valid;
        prev_probe = probe;
    end

    // One search. smode: 0 no stall, 1 three stall cycles per probe, 2 random stalls.
    // Called while the DUT is idle (or in its done cycle); start is sampled at the next edge.
    task automatic run_search(input logic [W-1:0] t, input logic m, input int smode,
                              input bit poke_busy);
        int n, cyc, phase;
        target = t;
        cur_mode = m;
        signed_cmp = m;
        n = model_push(t, m);
        start = 1'b1;
        cmp_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        signed_cmp = ~m;
        cyc = 1;
        check("busy_after_start", busy, 1);
        check("first_probe", probe, m ? 0 : 'h80);
        phase = 0;
        forever begin
            case (smode)
                0: cmp_valid = 1'b1;
                1: begin cmp_valid = (phase == 3); phase = (phase == 3) ? 0 : phase + 1; end
                default: cmp_valid = ($urandom_range(0, 2) != 0);
            endcase
            start = (poke_busy && n >= 3 && cyc == 2);
            @(negedge clk);
            if (done) break;
            if (cyc > 200) begin
                check("done_timeout", cyc, -1);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        cmp_valid = 1'b0;
        start = 1'b0;
        if (smode == 0) check("latency", cyc, n + 1);
        if (smode == 1) check("latency_stall", cyc, 4 * n + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_probe_valid", probe_valid, 0);
        check("rst_probe", probe, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_hit_eq", hit_eq, 0);

        // Directed cases
        run_search(8'hB5, 1'b0, 0, 1'b0);
        run_search(8'hFD, 1'b1, 0, 1'b0);
        run_search(8'h40, 1'b0, 0, 1'b0);
        run_search(8'h00, 1'b0, 0, 1'b0);
        run_search(8'h80, 1'b1, 1, 1'b0);
        run_search(8'h37, 1'b0, 1, 1'b0);
        // Start while busy is ignored; the following start lands in the done cycle.
        run_search(8'h5B, 1'b0, 0, 1'b1);
        run_search(8'hA3, 1'b0, 0, 1'b0);
        run_search(8'h7F, 1'b1, 0, 1'b0);

        // Reset during the fourth probe aborts with no done.
        @(posedge clk); #1;
        target = 8'h6B; cur_mode = 1'b0; signed_cmp = 1'b0;
        void'(model_push(8'h6B, 1'b0));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cmp_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cmp_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_probe_valid", probe_valid, 0);
        check("abort_probe", probe, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_hit_eq", hit_eq, 0);
        exp_probe.delete();
        exp_res.delete();
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        @(posedge clk); #1;
        run_search(8'h6B, 1'b0, 0, 1'b0);

        // Randomised searches, with random idle gaps or back-to-back starts.
        for (int i = 0; i < 40; i++) begin
            t = W'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            run_search(t, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("probes_drained", exp_probe.size(), 0);
        check("results_drained", exp_res.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
